uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// A write reaches the start bit on txd two clocks later; writes to a full FIFO are dropped and set sticky tx_overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tx_fifo_write,
  input  logic [7:0] tx_fifo_data,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_overflow,
  output logic       tx_busy,
  output logic       txd
);

  localparam int         DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;
  logic               bit_end;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  tx_byte;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign tx_fifo_empty = (count == '0);
  assign tx_fifo_full  = count[FIFO_AW];
  assign tx_busy       = (state != IDLE);
  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign pop           = !tx_fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push          = tx_fifo_write && (!tx_fifo_full || pop);

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= tx_fifo_data;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (tx_fifo_write && !push) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // txd is the registered image of the current state, so the line lags the FSM by one clock
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= tx_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
        PARITY:  txd <= ^tx_byte;
`endif
        default: txd <= 1'b1;
      endcase

      baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            tx_byte <= mem[rd_ptr];
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              tx_byte <= mem[rd_ptr];
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued bytes are matched bit-by-bit, cycle-by-cycle against txd.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int FRAME = CPB * FL;

  logic       sysclk        = 1'b0;
  logic       reset         = 1'b1;
  logic       tx_fifo_write = 1'b0;
  logic [7:0] tx_fifo_data  = 8'h00;
  logic       tx_fifo_full;
  logic       tx_fifo_empty;
  logic       tx_overflow;
  logic       tx_busy;
  logic       txd;

  int total       = 0;
  int bad         = 0;
  int cyc         = 0;
  int busy_cnt    = 0;
  int frames_done = 0;
  int wr_edge     = 0;

  logic [7:0]  sb[$];
  int          starts[$];
  bit          mon_act = 1'b0;
  int          mon_cnt = 0;
  logic [10:0] mon_frame = '1;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .tx_fifo_write(tx_fifo_write),
    .tx_fifo_data (tx_fifo_data),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_overflow  (tx_overflow),
    .tx_busy      (tx_busy),
    .txd          (txd)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (tx_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Decodes txd: each frame must match the oldest queued byte on every clock of every bit
  task automatic monitor();
    forever begin
      @(negedge sysclk);
      if (reset !== 1'b1) begin
        mon_act = 1'b0;
        sb.delete();
      end else begin
        if (!mon_act && txd === 1'b0) begin
          starts.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_frame", 32'(sb.size()), 32'd1);
          end else begin
            mon_act   = 1'b1;
            mon_cnt   = 0;
            mon_frame = make_frame(sb[0]);
          end
        end
        if (mon_act) begin
          check($sformatf("txd_bit%0d_byte%0h", mon_cnt / CPB, sb[0]),
                32'(txd), 32'(mon_frame[mon_cnt / CPB]));
          mon_cnt++;
          if (mon_cnt == FRAME) begin
            void'(sb.pop_front());
            frames_done++;
            mon_act = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    @(negedge sysclk);
    tx_fifo_write = 1'b1;
    tx_fifo_data  = b;
    if (acc) sb.push_back(b);
    wr_edge = cyc + 1;
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_write();
    @(negedge sysclk);
    tx_fifo_write = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge sysclk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge sysclk);
      t++;
    end
    check("frames_done", 32'(frames_done), 32'(n));
  endtask

  function automatic int start_at(input int idx);
    return (starts.size() > idx) ? starts[idx] : -1;
  endfunction

  initial begin
    int b0;
    int s0;
    int f0;
    int n0;

    fork
      monitor();
    join_none

    #1 reset = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_txd",   32'(txd),           32'd1);
    check("rst_busy",  32'(tx_busy),       32'd0);
    check("rst_ovf",   32'(tx_overflow),   32'd0);
    check("rst_empty", 32'(tx_fifo_empty), 32'd1);
    check("rst_full",  32'(tx_fifo_full),  32'd0);
    #2 reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // single byte: two-clock latency, frame length on tx_busy
    b0 = busy_cnt; s0 = starts.size(); f0 = frames_done;
    push(8'h55, 1'b1);
    n0 = wr_edge;
    check("single_not_empty", 32'(tx_fifo_empty), 32'd0);
    idle_write();
    wait_frames(f0 + 1, FRAME + 50);
    repeat (4) @(negedge sysclk);
    check("single_latency", 32'(start_at(s0) - n0), 32'd2);
    check("single_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME));
    check("single_idle_txd", 32'(txd), 32'd1);
    check("single_idle_busy", 32'(tx_busy), 32'd0);

    // back-to-back frames with no idle gap
    s0 = starts.size(); f0 = frames_done;
    push(8'h01, 1'b1);
    n0 = wr_edge;
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    idle_write();
    wait_cyc(n0 + 2 * FRAME);
    check("b2b_empty_before_pop3", 32'(tx_fifo_empty), 32'd0);
    @(negedge sysclk);
    check("b2b_empty_after_pop3", 32'(tx_fifo_empty), 32'd1);
    wait_frames(f0 + 3, 3 * FRAME + 50);
    check("b2b_latency", 32'(start_at(s0) - n0), 32'd2);
    check("b2b_gap1", 32'(start_at(s0 + 1) - start_at(s0)), 32'(FRAME));
    check("b2b_gap2", 32'(start_at(s0 + 2) - start_at(s0 + 1)), 32'(FRAME));

    // overflow: one byte in flight, four fill the FIFO, the fifth is dropped
    repeat (3) @(negedge sysclk);
    f0 = frames_done;
    push(8'hA0, 1'b1);
    push(8'hB1, 1'b1);
    push(8'hB2, 1'b1);
    push(8'hB3, 1'b1);
    check("ovf_not_full_at3", 32'(tx_fifo_full), 32'd0);
    push(8'hB4, 1'b1);
    check("ovf_full_at4", 32'(tx_fifo_full), 32'd1);
    check("ovf_clear_at4", 32'(tx_overflow), 32'd0);
    push(8'hB5, 1'b0);
    check("ovf_set_at5", 32'(tx_overflow), 32'd1);
    check("ovf_still_full", 32'(tx_fifo_full), 32'd1);
    idle_write();
    wait_frames(f0 + 5, 5 * FRAME + 50);
    repeat (2 * FRAME) @(negedge sysclk);
    check("ovf_frame_count", 32'(frames_done), 32'(f0 + 5));
    check("ovf_sticky", 32'(tx_overflow), 32'd1);
    check("ovf_drained", 32'(tx_fifo_empty), 32'd1);

    @(negedge sysclk);
    #2 reset = 1'b0;
    repeat (2) @(negedge sysclk);
    check("rst2_ovf_cleared", 32'(tx_overflow), 32'd0);
    #2 reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // write into a full FIFO on the same edge the STOP state pops
    f0 = frames_done;
    push(8'hC0, 1'b1);
    n0 = wr_edge;
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b1);
    push(8'hC3, 1'b1);
    push(8'hC4, 1'b1);
    idle_write();
    wait_cyc(n0 + FRAME);
    check("sim_full_before", 32'(tx_fifo_full), 32'd1);
    tx_fifo_write = 1'b1;
    tx_fifo_data  = 8'hC5;
    sb.push_back(8'hC5);
    @(posedge sysclk);
    #1;
    check("sim_full_after", 32'(tx_fifo_full), 32'd1);
    check("sim_no_ovf", 32'(tx_overflow), 32'd0);
    idle_write();
    wait_frames(f0 + 6, 6 * FRAME + 50);
    check("sim_no_ovf_end", 32'(tx_overflow), 32'd0);

    // reset during data bit 3 of 0xA5 with a second byte queued
    repeat (3) @(negedge sysclk);
    push(8'hA5, 1'b1);
    n0 = wr_edge;
    push(8'hA6, 1'b1);
    idle_write();
    wait_cyc(n0 + 2 + CPB * 4 + 1);
    check("mid_pre_rst_txd", 32'(txd), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_empty", 32'(tx_fifo_empty), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge sysclk);
    #2 reset = 1'b1;
    repeat (2) @(negedge sysclk);
    s0 = starts.size(); f0 = frames_done;
    push(8'h3C, 1'b1);
    n0 = wr_edge;
    idle_write();
    wait_frames(f0 + 1, FRAME + 50);
    check("post_rst_latency", 32'(start_at(s0) - n0), 32'd2);

    // 0x07 has three ones: parity bit is 1 when enabled
    b0 = busy_cnt; f0 = frames_done;
    push(8'h07, 1'b1);
    idle_write();
    wait_frames(f0 + 1, FRAME + 50);
    repeat (FRAME) @(negedge sysclk);
    check("x07_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME));
    check("final_frame_count", 32'(frames_done), 32'(f0 + 1));
    check("final_txd_idle", 32'(txd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
